// File: rtl/dtw_frame_streamer.sv
// dtw_frame_streamer
//
// Sits between the feature extractor and the DTW scorer. It collects one
// utterance of FRAMES x 12 feature bytes. On an accepted go pulse it sends
// the scorer a one-cycle start pulse. It then replays the buffer in the
// scorer's fixed 13-cycle frame cadence: 12 data bytes followed by a one-cycle
// zero gap. In compare passes it then captures the 26-bit score.
//
// Ports
//   clock, reset_n       system clock, asynchronous active-low reset
//   feat_in/feat_valid   feature byte write port (accepted only in IDLE)
//   buf_clear            empties the buffer (IDLE only, wins over feat_valid)
//   go                   starts one pass (IDLE with a full buffer only)
//   train_mode           sampled with go: 1 = train pass, 0 = compare pass
//   template_id          sampled with go, tags the captured result
//   dtw_in               byte stream to the scorer (zero outside STREAM)
//   dtw_train_en         train enable to the scorer, held for the whole pass
//   dtw_start            one-cycle start pulse to the scorer
//   dtw_done/dtw_score   scorer completion level and result
//   buf_full             buffer holds FRAMES*12 bytes
//   busy                 a pass is in progress
//   result/result_id     last captured compare score and its template id
//   result_valid         one-cycle pulse at the end of every pass
//   err_timeout          sticky: scorer did not finish a compare pass in time
//
// Optional feature: define DTW_BEST_TRACK_EN to add best_score/best_id. These
// outputs track the lowest compare score seen since reset or buf_clear.

module dtw_frame_streamer #(
    parameter int FRAMES  = 50,
    parameter int TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  feat_in,
    input  logic        feat_valid,
    input  logic        buf_clear,
    input  logic        go,
    input  logic        train_mode,
    input  logic [3:0]  template_id,
    output logic [7:0]  dtw_in,
    output logic        dtw_train_en,
    output logic        dtw_start,
    input  logic        dtw_done,
    input  logic [25:0] dtw_score,
    output logic        buf_full,
    output logic        busy,
    output logic [25:0] result,
    output logic [3:0]  result_id,
    output logic        result_valid,
    output logic        err_timeout
`ifdef DTW_BEST_TRACK_EN
    ,
    output logic [25:0] best_score,
    output logic [3:0]  best_id
`endif
);

    localparam int DEPTH = FRAMES * 12;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] DEPTH_LAST   = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAMES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    GAP_SLOT     = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t state_q, state_d;

    // The utterance buffer is plain storage. It is not reset, so it can map
    // onto RAM.
    logic [7:0] mem [DEPTH];
    logic       memWe;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          full_q, full_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [3:0]    slot_q, slot_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          done_q;
    logic          train_q, train_d;
    logic [3:0]    id_q, id_d;
    logic          train_en_q, train_en_d;
    logic          err_q, err_d;
    logic [25:0]   result_q, result_d;
    logic [3:0]    result_id_q, result_id_d;
`ifdef DTW_BEST_TRACK_EN
    logic [25:0]   best_q, best_d;
    logic [3:0]    best_id_q, best_id_d;
`endif

    // Only a fresh rising edge of dtw_done counts. A level that is still
    // high from the previous pass is ignored.
    logic doneRise;
    assign doneRise = dtw_done && !done_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. Every one of them returns to zero on reset, except
    // best_q, which starts at the largest possible score.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            full_q      <= 1'b0;
            rd_ptr_q    <= '0;
            frame_q     <= '0;
            slot_q      <= '0;
            tcnt_q      <= '0;
            done_q      <= 1'b0;
            train_q     <= 1'b0;
            id_q        <= '0;
            train_en_q  <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            result_id_q <= '0;
`ifdef DTW_BEST_TRACK_EN
            best_q      <= 26'h3FFFFFF;
            best_id_q   <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_q     <= frame_d;
            slot_q      <= slot_d;
            tcnt_q      <= tcnt_d;
            done_q      <= dtw_done;
            train_q     <= train_d;
            id_q        <= id_d;
            train_en_q  <= train_en_d;
            err_q       <= err_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
`ifdef DTW_BEST_TRACK_EN
            best_q      <= best_d;
            best_id_q   <= best_id_d;
`endif
        end
    end

    // Buffer write port. memWe is raised only while the pointer is in
    // range, that is, when the buffer is not full.
    always_ff @(posedge clock) begin
        if (memWe) begin
            mem[wr_ptr_q] <= feat_in;
        end
    end

    // Next-state and datapath logic.
    //
    // The read pointer advances only on data slots. At each gap it
    // therefore already points at the first byte of the next frame.
    // Writes and buffer clears happen only in IDLE, so the buffer cannot
    // change during a replay.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        full_d      = full_q;
        rd_ptr_d    = rd_ptr_q;
        frame_d     = frame_q;
        slot_d      = slot_q;
        tcnt_d      = tcnt_q;
        train_d     = train_q;
        id_d        = id_q;
        train_en_d  = train_en_q;
        err_d       = err_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        memWe       = 1'b0;
`ifdef DTW_BEST_TRACK_EN
        best_d      = best_q;
        best_id_d   = best_id_q;
`endif

        case (state_q)
            IDLE: begin
                if (buf_clear) begin
                    wr_ptr_d = '0;
                    full_d   = 1'b0;
`ifdef DTW_BEST_TRACK_EN
                    best_d    = 26'h3FFFFFF;
                    best_id_d = '0;
`endif
                end else if (feat_valid && !full_q) begin
                    memWe    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == DEPTH_LAST) begin
                        full_d = 1'b1;
                    end
                end
                if (go && full_q) begin
                    state_d    = START;
                    train_d    = train_mode;
                    id_d       = template_id;
                    train_en_d = train_mode;
                    err_d      = 1'b0;
                end
            end

            START: begin
                state_d  = STREAM;
                rd_ptr_d = '0;
                frame_d  = '0;
                slot_d   = '0;
            end

            STREAM: begin
                if (slot_q == GAP_SLOT) begin
                    slot_d = '0;
                    if (frame_q == FRAME_LAST) begin
                        state_d = WAIT_DONE;
                        tcnt_d  = '0;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end else begin
                    slot_d   = slot_q + 4'd1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (train_q) begin
                    state_d = RESULT;
                end else if (doneRise) begin
                    state_d     = RESULT;
                    result_d    = dtw_score;
                    result_id_d = id_q;
`ifdef DTW_BEST_TRACK_EN
                    // The comparison is strict, so a tie keeps the older entry.
                    if (dtw_score < best_q) begin
                        best_d    = dtw_score;
                        best_id_d = id_q;
                    end
`endif
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    state_d = RESULT;
                    err_d   = 1'b1;
                end
            end

            RESULT: begin
                state_d    = IDLE;
                train_en_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. The strobes are decoded straight from the state register, so
    // an asynchronous reset clears them at once.
    assign dtw_in       = (state_q == STREAM && slot_q != GAP_SLOT) ? mem[rd_ptr_q] : 8'h00;
    assign dtw_start    = (state_q == START);
    assign dtw_train_en = train_en_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == RESULT);
    assign buf_full     = full_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign err_timeout  = err_q;
`ifdef DTW_BEST_TRACK_EN
    assign best_score   = best_q;
    assign best_id      = best_id_q;
`endif

endmodule
